// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, hardwired-zero index and pending-vector type for the scoreboarded register file.
package regfile_pkg;
    localparam int DEF_WIDTH  = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NREAD  = 2;
    localparam int ZERO_REG   = 0;
    typedef logic [2**DEF_ADDR_W-1:0] pending_vec_t;
endpackage

// File: rtl/regfile_entry.sv
// regfile_entry: one nonzero register with its pending bit; a reservation wins over the clearing write.
module regfile_entry import regfile_pkg::*; #(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int IDX    = 1
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_rsv_en,
    input  logic [ADDR_W-1:0] i_rsv_addr,
    output logic [WIDTH-1:0]  o_data,
    output logic              o_pend
);
    logic [WIDTH-1:0] r_data;
    logic             r_pend;
    logic             w_wr;
    logic             w_rsv;
    assign w_wr  = i_we && i_waddr == ADDR_W'(IDX);
    assign w_rsv = i_rsv_en && i_rsv_addr == ADDR_W'(IDX);
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
            r_pend <= 1'b0;
        end else begin
            if (w_wr) r_data <= i_wdata;
            r_pend <= w_rsv ? 1'b1 : w_wr ? 1'b0 : r_pend;
        end
    end
    assign o_data = r_data;
    assign o_pend = r_pend;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read register file with per-register pending scoreboard and combinational reads.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb import regfile_pkg::*; #(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREAD  = DEF_NREAD
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic [NREAD*ADDR_W-1:0] raddr,
    output logic [NREAD*WIDTH-1:0]  rdata,
    input  logic                    rsv_en,
    input  logic [ADDR_W-1:0]       rsv_addr,
    output logic [NREAD-1:0]        busy
);
    localparam int DEPTH = 2**ADDR_W;
    logic [WIDTH-1:0] w_q [DEPTH];
    logic [DEPTH-1:0] w_pend;
    assign w_q[ZERO_REG]    = '0;
    assign w_pend[ZERO_REG] = 1'b0;
    for (genvar g = 1; g < DEPTH; g++) begin : g_ent
        regfile_entry #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .IDX(g)) u_entry (
            .clk        (clk),
            .i_rst_n    (rst),
            .i_we       (we),
            .i_waddr    (waddr),
            .i_wdata    (wdata),
            .i_rsv_en   (rsv_en),
            .i_rsv_addr (rsv_addr),
            .o_data     (w_q[g]),
            .o_pend     (w_pend[g])
        );
    end
    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic              w_hit;
        assign w_ra = raddr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        assign w_hit = we && waddr != ADDR_W'(ZERO_REG) && w_ra == waddr;
`else
        assign w_hit = 1'b0;
`endif
        // forwarded data clears busy unless the same address is being re-reserved this cycle
        assign rdata[k*WIDTH +: WIDTH] = !rst ? '0 : w_hit ? wdata : w_q[w_ra];
        assign busy[k] = rst && (w_hit ? (rsv_en && rsv_addr == w_ra) : w_pend[w_ra]);
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vectors against a behavioural array model checked every falling edge.
module tb_regfile_sb;
    import regfile_pkg::*;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [9:0]  raddr = '0;
    logic [63:0] rdata;
    logic        rsv_en = 1'b0;
    logic [4:0]  rsv_addr = '0;
    logic [1:0]  busy;
    int n_tests = 0;
    int n_fail = 0;
    logic [31:0]  m_reg [32] = '{default: '0};
    pending_vec_t m_pend = '0;

    regfile_sb dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_reg[i] = '0;
            m_pend = '0;
        end else begin
            if (we && waddr != 0) begin
                m_reg[waddr] = wdata;
                m_pend[waddr] = 1'b0;
            end
            if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [4:0]  ra;
            logic [31:0] ed;
            logic        eb;
            ra = raddr[k*5 +: 5];
            ed = m_reg[ra];
            eb = m_pend[ra];
`ifdef REGFILE_BYPASS_EN
            if (we && waddr != 0 && ra == waddr) begin
                ed = wdata;
                eb = rsv_en && rsv_addr == ra;
            end
`endif
            if (!rst) begin
                ed = '0;
                eb = 1'b0;
            end
            chk($sformatf("model rdata%0d", k), 64'(rdata[k*32 +: 32]), 64'(ed));
            chk($sformatf("model busy%0d", k), 64'(busy[k]), 64'(eb));
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic look;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        look();
        chk("reset rdata", rdata, 64'h0);
        chk("reset busy", 64'(busy), 64'h0);
        we = 1; waddr = 5; wdata = 32'hDEADBEEF;
        step();
        we = 0; raddr = {5'd0, 5'd5};
        look();
        chk("r5 data", 64'(rdata[31:0]), 64'hDEADBEEF);
        chk("r5 busy", 64'(busy[0]), 64'h0);
        we = 1; waddr = 0; wdata = 32'hFFFFFFFF; raddr = '0;
        step();
        we = 0;
        look();
        chk("r0 data", rdata, 64'h0);
        chk("r0 busy", 64'(busy), 64'h0);
        rsv_en = 1; rsv_addr = 0;
        step();
        rsv_en = 0;
        look();
        chk("r0 rsv busy", 64'(busy), 64'h0);
        rsv_en = 1; rsv_addr = 7;
        step();
        rsv_en = 0; raddr = {5'd7, 5'd0};
        look();
        chk("r7 pend", 64'(busy[1]), 64'h1);
        we = 1; waddr = 7; wdata = 32'h12;
        step();
        we = 0;
        look();
        chk("r7 clr busy", 64'(busy[1]), 64'h0);
        chk("r7 data", 64'(rdata[63:32]), 64'h12);
        rsv_en = 1; rsv_addr = 9; we = 1; waddr = 9; wdata = 32'h55;
        step();
        rsv_en = 0; we = 0; raddr = {5'd9, 5'd9};
        look();
        chk("r9 data", rdata, 64'h00000055_00000055);
        chk("r9 busy", 64'(busy), 64'h3);
        rsv_en = 1; rsv_addr = 3;
        step();
        rsv_en = 0; we = 1; waddr = 3; wdata = 32'hA5; raddr = {5'd9, 5'd3};
        look();
`ifdef REGFILE_BYPASS_EN
        chk("r3 same data", 64'(rdata[31:0]), 64'hA5);
        chk("r3 same busy", 64'(busy[0]), 64'h0);
`else
        chk("r3 same data", 64'(rdata[31:0]), 64'h0);
        chk("r3 same busy", 64'(busy[0]), 64'h1);
`endif
        step();
        we = 0;
        look();
        chk("r3 next data", 64'(rdata[31:0]), 64'hA5);
        chk("r3 next busy", 64'(busy[0]), 64'h0);
        for (int i = 1; i < 32; i++) begin
            we = 1; waddr = 5'(i); wdata = 32'(i) * 32'h01010101;
            step();
        end
        we = 0; rsv_en = 1; rsv_addr = 4;
        step();
        rsv_en = 0; raddr = {5'd4, 5'd31};
        look();
        chk("fill data", rdata, 64'h04040404_1F1F1F1F);
        chk("fill busy", 64'(busy), 64'h2);
        #2 rst = 0;
        we = 1; waddr = 6; wdata = 32'hCAFE; raddr = {5'd6, 5'd4};
        #1;
        chk("midrst data", rdata, 64'h0);
        chk("midrst busy", 64'(busy), 64'h0);
        step();
        we = 0; rst = 1;
        look();
        chk("lost write", rdata, 64'h0);
        chk("post rst busy", 64'(busy), 64'h0);
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
